// File: rtl/preamble_serializer_101.sv
// Serial transmitter: emits a 1-0-1 sync preamble, then a parallel payload MSB first,
// then a programmable run of idle zeros, one bit per clock on a registered line.
module preamble_serializer_101 #(
  parameter int DATA_WIDTH = 8,
  parameter int GAP_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  valid,
  output logic                  ready,
  output logic                  tx,
  output logic                  busy,
  output logic                  frame_done
);

  localparam int CNT_W = $clog2(DATA_WIDTH + 1);
  localparam logic [CNT_W-1:0] BIT_LOAD = CNT_W'(DATA_WIDTH - 1);
  localparam logic [3:0]       GAP_LOAD = 4'(GAP_CYCLES - 1);

  if (DATA_WIDTH < 1 || DATA_WIDTH > 32) begin : g_bad_width
    $error("preamble_serializer_101: DATA_WIDTH must be 1..32");
  end
  if (GAP_CYCLES < 0 || GAP_CYCLES > 15) begin : g_bad_gap
    $error("preamble_serializer_101: GAP_CYCLES must be 0..15");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PRE  = 2'd1,
    DATA = 2'd2,
    GAP  = 2'd3
  } state_t;

  state_t                  state_q, state_d;
  logic [1:0]              pre_idx_q, pre_idx_d;
  logic [CNT_W-1:0]        bit_cnt_q, bit_cnt_d;
  logic [3:0]              gap_cnt_q, gap_cnt_d;
  logic [DATA_WIDTH-1:0]   shift_q, shift_d;
  logic                    tx_d;

  assign ready = (state_q == IDLE);

  // Next-state logic; tx_d is the line level for the state being entered.
  always_comb begin
    state_d   = state_q;
    pre_idx_d = pre_idx_q;
    bit_cnt_d = bit_cnt_q;
    gap_cnt_d = gap_cnt_q;
    shift_d   = shift_q;
    tx_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (valid) begin
          state_d   = PRE;
          pre_idx_d = 2'd0;
          shift_d   = data_in;
          tx_d      = 1'b1;
        end
      end
      PRE: begin
        if (pre_idx_q == 2'd2) begin
          state_d   = DATA;
          bit_cnt_d = BIT_LOAD;
          tx_d      = shift_q[DATA_WIDTH-1];
          shift_d   = shift_q << 1;
        end else begin
          pre_idx_d = pre_idx_q + 2'd1;
          tx_d      = (pre_idx_q == 2'd1);
        end
      end
      DATA: begin
        if (bit_cnt_q == '0) begin
          if (GAP_CYCLES > 0) begin
            state_d   = GAP;
            gap_cnt_d = GAP_LOAD;
          end else begin
            state_d = IDLE;
          end
        end else begin
          bit_cnt_d = bit_cnt_q - CNT_W'(1);
          tx_d      = shift_q[DATA_WIDTH-1];
          shift_d   = shift_q << 1;
        end
      end
      GAP: begin
        if (gap_cnt_q == 4'd0) begin
          state_d = IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q - 4'd1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      pre_idx_q  <= 2'd0;
      bit_cnt_q  <= '0;
      gap_cnt_q  <= 4'd0;
      shift_q    <= '0;
      tx         <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state_q    <= state_d;
      pre_idx_q  <= pre_idx_d;
      bit_cnt_q  <= bit_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      shift_q    <= shift_d;
      tx         <= tx_d;
      busy       <= (state_d != IDLE);
      frame_done <= (state_d == DATA) && (bit_cnt_d == '0);
    end
  end

endmodule

// File: tb/tb_preamble_serializer_101.sv
// Scoreboard bench for preamble_serializer_101: a W=8/G=2 instance and a W=1/G=0 instance.
module tb_preamble_serializer_101;

  localparam int W0 = 8;
  localparam int G0 = 2;
  localparam int W1 = 1;
  localparam int G1 = 0;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [W0-1:0] data_a;
  logic [W1-1:0] data_b;
  logic          valid_a, valid_b;
  logic          ready_a, tx_a, busy_a, fd_a;
  logic          ready_b, tx_b, busy_b, fd_b;

  always #5 clk = ~clk;

  preamble_serializer_101 #(.DATA_WIDTH(W0), .GAP_CYCLES(G0)) dut_a (
    .clk(clk), .reset_n(reset_n), .data_in(data_a), .valid(valid_a),
    .ready(ready_a), .tx(tx_a), .busy(busy_a), .frame_done(fd_a)
  );

  preamble_serializer_101 #(.DATA_WIDTH(W1), .GAP_CYCLES(G1)) dut_b (
    .clk(clk), .reset_n(reset_n), .data_in(data_b), .valid(valid_b),
    .ready(ready_b), .tx(tx_b), .busy(busy_b), .frame_done(fd_b)
  );

  typedef struct packed {
    logic tx;
    logic fd;
  } exp_t;

  exp_t sb_q[$];
  int   push_cyc[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   sel = 0;
  logic idle_now = 1'b1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d, dut %0d)", tag, got, exp, cyc, sel);
    end
  endtask

  // Expected per-cycle line levels for a whole frame, starting with the transfer edge.
  task automatic push_frame(input logic [31:0] d, input int w, input int g);
    sb_q.push_back('{tx: 1'b1, fd: 1'b0});
    sb_q.push_back('{tx: 1'b0, fd: 1'b0});
    sb_q.push_back('{tx: 1'b1, fd: 1'b0});
    for (int i = w - 1; i >= 0; i--) sb_q.push_back('{tx: d[i], fd: (i == 0)});
    for (int i = 0; i < g; i++) sb_q.push_back('{tx: 1'b0, fd: 1'b0});
  endtask

  // Called in the low clock phase: drive inputs, cross one rising edge, check at the falling edge.
  task automatic tick(input logic v, input logic [31:0] d);
    logic t, b, f, r;
    exp_t e;
    if (sel == 0) begin valid_a = v; data_a = d[W0-1:0]; end
    else          begin valid_b = v; data_b = d[W1-1:0]; end
    if (v && idle_now && reset_n) begin
      push_frame(d, (sel != 0) ? W1 : W0, (sel != 0) ? G1 : G0);
      push_cyc.push_back(cyc);
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
    if (sel == 0) begin t = tx_a; b = busy_a; f = fd_a; r = ready_a; end
    else          begin t = tx_b; b = busy_b; f = fd_b; r = ready_b; end
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk("tx", t, e.tx);
      chk("frame_done", f, e.fd);
      chk("busy", b, 1);
      chk("ready", r, 0);
      idle_now = 1'b0;
    end else begin
      chk("idle_tx", t, 0);
      chk("idle_frame_done", f, 0);
      chk("idle_busy", b, 0);
      chk("idle_ready", r, 1);
      idle_now = 1'b1;
    end
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 32'hDEAD_BEEF);
  endtask

  initial begin
    reset_n = 1'b0;
    valid_a = 1'b0; data_a = '0;
    valid_b = 1'b0; data_b = '0;
    @(negedge clk);

    // Reset held with valid high: nothing may start
    for (int i = 0; i < 5; i++) tick(1'b1, 32'hFF);
    chk("frames_during_reset", push_cyc.size(), 0);
    reset_n = 1'b1;
    tick(1'b1, 32'hFF);
    chk("first_transfer_after_release", push_cyc.size(), 1);
    drain(16);

    // Single frame 0xA5
    tick(1'b1, 32'hA5);
    drain(15);

    // Back-to-back: 0x00 then 0xFF with valid held high
    push_cyc.delete();
    tick(1'b1, 32'h00);
    for (int i = 0; i < 20; i++) tick(1'b1, 32'hFF);
    chk("b2b_frames", push_cyc.size(), 2);
    if (push_cyc.size() >= 2) chk("b2b_pitch", push_cyc[1] - push_cyc[0], 14);
    drain(16);

    // Ignored valid while busy
    push_cyc.delete();
    tick(1'b1, 32'h3C);
    tick(1'b0, 32'h00);
    tick(1'b0, 32'h00);
    tick(1'b1, 32'hC3);
    drain(14);
    chk("ignored_valid_frames", push_cyc.size(), 1);

    // Mid-frame reset during the 4th payload bit of 0xF0
    tick(1'b1, 32'hF0);
    for (int i = 0; i < 6; i++) tick(1'b0, 32'h00);
    chk("pre_reset_tx", tx_a, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("async_tx", tx_a, 0);
    chk("async_busy", busy_a, 0);
    chk("async_frame_done", fd_a, 0);
    chk("async_ready", ready_a, 1);
    sb_q.delete();
    idle_now = 1'b1;
    drain(2);
    reset_n = 1'b1;
    drain(20);

    // Corner instance W=1, G=0 with valid held high
    sel = 1;
    push_cyc.delete();
    drain(2);
    for (int i = 0; i < 12; i++) tick(1'b1, 32'h1);
    chk("w1_frames", push_cyc.size(), 3);
    if (push_cyc.size() >= 2) chk("w1_pitch", push_cyc[1] - push_cyc[0], 5);
    drain(8);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/preamble_serializer_101.md
Name: preamble_serializer_101

Overview:
- Transmit-side counterpart of the team's "101" sequence detection path.
- Accepts a parallel payload word over a valid/ready handshake and emits it on a single serial line, one bit per clock.
- Each frame is the 3-bit sync preamble 1-0-1, then the payload MSB first, then a programmable run of idle zeros.
- Feeds serial links whose far end hunts for the 101 marker.

Parameters:
- DATA_WIDTH, 8, payload bits per frame (legal range 1 to 32).
- GAP_CYCLES, 2, forced idle-zero cycles after the last payload bit (legal range 0 to 15).

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous active-low reset.
- data_in  input  DATA_WIDTH  payload word, sampled on handshake.
- valid  input  1  producer has a word on data_in.
- ready  output  1  block can accept a word; equals (state==IDLE).
- tx  output  1  serial line, registered; idle level 0.
- busy  output  1  registered; high in every non-IDLE state.
- frame_done  output  1  registered; one-cycle pulse coincident with the last payload bit on tx.

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-low on reset_n.
- While reset_n is low:
  - state=IDLE; tx=0, busy=0, frame_done=0, ready=1.
  - Shift register and counters are cleared.
- States: IDLE, PRE, DATA, GAP.
  - Next-state/combinational logic is separate from the clocked state register.
  - Default case returns to IDLE.
- Handshake: transfer occurs at rising edge k when valid=1 and ready=1.
  - data_in is latched into the shift register at edge k.
  - valid while ready=0 is ignored; no data is captured or queued.
  - data_in is don't-care except at the transfer edge.
- Timeline after the transfer at edge k (W=DATA_WIDTH, G=GAP_CYCLES), each row being tx after the given edge:
  - k: tx=1 (PRE bit 0).
  - k+1: tx=0 (PRE bit 1).
  - k+2: tx=1 (PRE bit 2).
  - k+3 .. k+2+W: payload bits, MSB first.
  - k+3+W .. k+2+W+G: tx=0 (GAP).
  - k+3+W+G: IDLE, ready=1.
- busy is 1 from edge k through the last GAP cycle, i.e. 3+W+G cycles.
- frame_done=1 only during the cycle tx carries payload bit 0 (after edge k+2+W).
- G=0: DATA goes directly to IDLE after the last bit.
  - Minimum frame pitch is 3+W+1 cycles; IDLE always lasts at least one cycle with tx=0.
  - Back-to-back frames therefore always have one zero between the last payload bit and the next preamble.
- Counters:
  - Preamble index: 2 bits.
  - Data bit counter: $clog2(DATA_WIDTH+1) bits, counts W-1 down to 0.
  - Gap counter: 4 bits, counts G-1 down to 0.
  - No wrap-around beyond terminal values; each counter reloads on state entry.
- Payload containing 101 patterns is sent unmodified; no bit stuffing.
  - The receiver may false-detect inside payload; this is accepted at system level.
- Reset asserted mid-frame:
  - Outputs go to their reset values immediately (asynchronously).
  - The partial frame is discarded and is not resumed after release.
  - First legal transfer is at the first rising edge with reset_n=1.
- valid held high continuously: a new frame starts at each IDLE cycle; frames never overlap.

Test Plan:
- Reset check: reset_n=0 with valid=1, data_in=0xFF for 5 cycles, then release -> tx=0, busy=0, frame_done=0, ready=1 throughout reset; no frame starts until the first edge after release.
- Single frame (W=8, G=2), data_in=0xA5 handshaked at edge k:
  - tx after edges k..k+12 = 1,0,1,1,0,1,0,0,1,0,1,0,0.
  - frame_done high only after edge k+10.
  - ready returns to 1 after edge k+13; busy high for 13 cycles.
- Back-to-back: valid held high, data 0x00 then 0xFF -> second preamble starts exactly 14 cycles after the first; the second frame tx = 1,0,1,1,1,1,1,1,1,1,1,0,0.
- Ignored valid: during frame 0x3C, pulse valid with data_in=0xC3 while ready=0 -> frame bits are unchanged (0,0,1,1,1,1,0,0 after preamble); no second frame starts.
- Mid-frame reset: assert reset_n low during the 4th payload bit of 0xF0 -> tx=0 and busy=0 in the same cycle; after release with valid=0, tx stays 0 for 20 cycles.
- Parameter corner (W=1, G=0), data_in=1 -> tx = 1,0,1,1, then 0 for one IDLE cycle; frame_done coincides with the 4th bit; the next transfer is accepted in that IDLE cycle.
